// File: rtl/iram_arbiter.sv
// ----------------------------------------------------------------------------
// iram_arbiter
//
// Purpose:
//   Shares the single-port bytecode instruction RAM between the JIT decoder
//   front end (opcode/parameter fetches) and the host loader (image writes
//   and read-back). One RAM access is granted per cycle, read data is routed
//   back to whichever requester issued the read, and the decoder stall
//   (o_waiting) is generated here.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_reset        asynchronous reset, active low
//   i_dec_req      decoder read request, held until o_dec_gnt
//   i_dec_adr      decoder read address
//   o_dec_gnt      decoder access issued this cycle (combinational)
//   o_dec_data     decoder read data, registered, held until next o_dec_valid
//   o_dec_valid    one-cycle pulse, o_dec_data updated
//   o_waiting      decoder stall
//   i_ld_req       loader request
//   i_ld_we        loader write (1) / read (0)
//   i_ld_lock      loader requests burst ownership
//   i_ld_adr       loader address
//   i_ld_wdata     loader write data
//   o_ld_gnt       loader access issued this cycle (combinational)
//   o_ld_rdata     loader read data, registered
//   o_ld_valid     one-cycle pulse, o_ld_rdata updated
//   o_ram_en       iram enable
//   o_ram_we       iram write enable
//   o_ram_adr      iram address
//   o_ram_wdata    iram write data
//   i_ram_rdata    iram read data, valid RD_LAT cycles after the enabled read
// ----------------------------------------------------------------------------
module iram_arbiter #(
    parameter int ADR_W     = 16,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    // decoder port
    input  logic             i_dec_req,
    input  logic [ADR_W-1:0] i_dec_adr,
    output logic             o_dec_gnt,
    output logic [7:0]       o_dec_data,
    output logic             o_dec_valid,
    output logic             o_waiting,
    // loader port
    input  logic             i_ld_req,
    input  logic             i_ld_we,
    input  logic             i_ld_lock,
    input  logic [ADR_W-1:0] i_ld_adr,
    input  logic [7:0]       i_ld_wdata,
    output logic             o_ld_gnt,
    output logic [7:0]       o_ld_rdata,
    output logic             o_ld_valid,
    // iram macro
    output logic             o_ram_en,
    output logic             o_ram_we,
    output logic [ADR_W-1:0] o_ram_adr,
    output logic [7:0]       o_ram_wdata,
    input  logic [7:0]       i_ram_rdata
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    // State records who owned the most recent granted cycle.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DEC_OWN = 2'd1,
        ST_LD_OWN  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [CNT_W-1:0] r_burst_cnt;
    logic             r_dec_pending;

    // Read tag pipeline: one {valid, owner} slot per cycle of RAM latency.
    // r_tag_dec=1 marks a decoder read, 0 a loader read.
    logic [RD_LAT-1:0] r_tag_vld;
    logic [RD_LAT-1:0] r_tag_dec;

    logic [7:0]       r_dec_data;
    logic             r_dec_valid;
    logic [7:0]       r_ld_rdata;
    logic             r_ld_valid;

    logic             w_dec_elig;
    logic             w_ld_elig;
    logic             w_lock_hold;
    logic             w_dec_gnt;
    logic             w_ld_gnt;
    logic             w_issue_rd;
    logic             w_ret_dec;
    logic             w_ret_ld;

    // ------------------------------------------------------------------
    // Grant decision
    // ------------------------------------------------------------------
    // The decoder is limited to one outstanding read, so it drops out of
    // arbitration while its previous fetch is still in the RAM pipeline.
    assign w_dec_elig = i_dec_req & ~r_dec_pending;
    assign w_ld_elig  = i_ld_req;

    // A locked loader keeps the RAM under contention only while its burst
    // allowance lasts; once the counter saturates the decoder gets a slot.
    assign w_lock_hold = (r_state == ST_LD_OWN) & i_ld_lock &
                         (r_burst_cnt < BURST_MAX);

    always_comb begin
        w_dec_gnt    = 1'b0;
        w_ld_gnt     = 1'b0;
        w_state_next = ST_IDLE;

        // Gating with the reset input keeps the RAM quiet during reset even
        // though requests may already be asserted.
        if (i_reset) begin
            if (w_dec_elig && !w_ld_elig) begin
                w_dec_gnt = 1'b1;
            end else if (!w_dec_elig && w_ld_elig) begin
                w_ld_gnt = 1'b1;
            end else if (w_dec_elig && w_ld_elig) begin
                if (w_lock_hold) begin
                    w_ld_gnt = 1'b1;
                end else if (r_state == ST_DEC_OWN) begin
                    // alternate away from the last owner
                    w_ld_gnt = 1'b1;
                end else begin
                    // from IDLE or after a loader cycle the decoder wins
                    w_dec_gnt = 1'b1;
                end
            end
        end

        if (w_dec_gnt) begin
            w_state_next = ST_DEC_OWN;
        end else if (w_ld_gnt) begin
            w_state_next = ST_LD_OWN;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Burst counter: counts loader grants taken while the decoder is
    // asking for the RAM; any decoder grant or an idle decoder resets it.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_burst_cnt <= '0;
        end else if (!i_dec_req || w_dec_gnt) begin
            r_burst_cnt <= '0;
        end else if (w_ld_gnt && (r_burst_cnt != BURST_MAX)) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // RAM port mux. Grants are one-hot, so the loader select can take
    // priority without changing behaviour.
    // ------------------------------------------------------------------
    assign o_ram_en    = w_dec_gnt | w_ld_gnt;
    assign o_ram_we    = w_ld_gnt & i_ld_we;
    assign o_ram_adr   = w_ld_gnt  ? i_ld_adr  :
                         w_dec_gnt ? i_dec_adr : '0;
    assign o_ram_wdata = w_ld_gnt  ? i_ld_wdata : 8'h00;

    assign o_dec_gnt   = w_dec_gnt;
    assign o_ld_gnt    = w_ld_gnt;

    // ------------------------------------------------------------------
    // Read tag pipeline and return registers
    // ------------------------------------------------------------------
    // Writes never enter the pipeline, so they produce no valid pulse.
    assign w_issue_rd = w_dec_gnt | (w_ld_gnt & ~i_ld_we);

    // Tag leaving the pipeline lines up with i_ram_rdata for that read.
    assign w_ret_dec  = r_tag_vld[RD_LAT-1] &  r_tag_dec[RD_LAT-1];
    assign w_ret_ld   = r_tag_vld[RD_LAT-1] & ~r_tag_dec[RD_LAT-1];

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            // Clearing the tags drops every read still in flight.
            r_tag_vld   <= '0;
            r_tag_dec   <= '0;
            r_dec_data  <= 8'h00;
            r_dec_valid <= 1'b0;
            r_ld_rdata  <= 8'h00;
            r_ld_valid  <= 1'b0;
        end else begin
            r_tag_vld[0] <= w_issue_rd;
            r_tag_dec[0] <= w_dec_gnt;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_dec[i] <= r_tag_dec[i-1];
            end

            r_dec_valid <= w_ret_dec;
            if (w_ret_dec) begin
                r_dec_data <= i_ram_rdata;
            end

            r_ld_valid <= w_ret_ld;
            if (w_ret_ld) begin
                r_ld_rdata <= i_ram_rdata;
            end
        end
    end

    // Pending spans issue up to (not including) the dec_valid cycle, so a
    // decoder that advances on dec_valid can be granted in that same cycle
    // and back-to-back fetches land on alternate cycles.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_dec_pending <= 1'b0;
        end else if (w_dec_gnt) begin
            r_dec_pending <= 1'b1;
        end else if (w_ret_dec) begin
            r_dec_pending <= 1'b0;
        end
    end

    assign o_dec_data  = r_dec_data;
    assign o_dec_valid = r_dec_valid;
    assign o_ld_rdata  = r_ld_rdata;
    assign o_ld_valid  = r_ld_valid;

    // Stall while the fetch is blocked or still in flight; released in the
    // dec_valid cycle so the decoder consumes o_dec_data there.
    assign o_waiting = i_reset &
                       ((i_dec_req & ~w_dec_gnt) |
                        (r_dec_pending & ~r_dec_valid));

endmodule

// File: doc/iram_arbiter.md
Name: iram_arbiter

Overview:
- Shares the single-port bytecode instruction RAM (iram) between two requesters:
  - the JIT decoder front end, which fetches opcodes and parameters for the decode state machine;
  - the host loader, which writes and reads back bytecode images.
- Grants one RAM access per cycle and routes read data back to its owner.
- Generates the `waiting` stall that freezes the decode state machine while its fetch is blocked or in flight.
- Sits between the decoder, the loader port and the iram macro.

Parameters:
- ADR_W, 16, iram address width.
- RD_LAT, 1, iram read latency in cycles (1..4).
- MAX_BURST, 8, maximum consecutive loader grants under ld_lock while the decoder is requesting.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- dec_req  in  1  decoder read request; held until dec_gnt.
- dec_adr  in  ADR_W  decoder read address.
- dec_gnt  out  1  decoder access issued this cycle (combinational).
- dec_data  out  8  decoder read data; registered, held until the next dec_valid.
- dec_valid  out  1  one-cycle pulse; dec_data updated.
- waiting  out  1  decoder stall.
- ld_req  in  1  loader request.
- ld_we  in  1  loader write (1) or read (0).
- ld_lock  in  1  loader requests burst ownership.
- ld_adr  in  ADR_W  loader address.
- ld_wdata  in  8  loader write data.
- ld_gnt  out  1  loader access issued this cycle (combinational).
- ld_rdata  out  8  loader read data; registered.
- ld_valid  out  1  one-cycle pulse; ld_rdata updated.
- ram_en  out  1  iram enable.
- ram_we  out  1  iram write enable.
- ram_adr  out  ADR_W  iram address.
- ram_wdata  out  8  iram write data.
- ram_rdata  in  8  iram read data, valid RD_LAT cycles after the enabled read.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE, burst_cnt=0, read tag pipeline cleared.
  - dec_data=0, dec_valid=0, ld_rdata=0, ld_valid=0.
  - Grants and ram_* are 0 while reset is low.
  - Reads in flight when reset asserts are dropped; no valid pulse follows.
- Access rule: a transfer happens on a rising edge when req&gnt.
  - ram_en=dec_gnt|ld_gnt; ram_we=ld_gnt&ld_we.
  - ram_adr and ram_wdata are muxed from the granted requester.
  - dec_gnt and ld_gnt are never high together.
- dec_pending is high from a decoder issue until its dec_valid cycle.
  - dec_gnt is forced 0 while dec_pending: the decoder has at most one read outstanding.
  - Loader reads may pipeline, one per cycle.
- FSM state = owner of the last granted cycle: IDLE, DEC_OWN, LD_OWN.
  - The state goes to IDLE after a cycle with no grant.
- Grant decision, per cycle:
  - Only the decoder is eligible: decoder granted.
  - Only the loader requests: loader granted.
  - Both eligible, state=LD_OWN, ld_lock=1 and burst_cnt<MAX_BURST: loader granted.
  - Both eligible otherwise: grant goes to the requester not owning the last cycle. From IDLE, the decoder wins.
- burst_cnt:
  - Increments on each loader grant while dec_req=1.
  - Clears on any decoder grant, or when dec_req=0.
  - Saturates at MAX_BURST, which forces the next contended slot to the decoder.
- Read return:
  - A tag pipeline of depth RD_LAT carries {valid, owner} per issued read.
  - At the pipeline exit, ram_rdata is registered into dec_data or ld_rdata and the matching valid pulses one cycle.
  - Total read latency from the grant edge to the valid pulse is RD_LAT+1 cycles.
  - Loader writes produce no valid pulse.
- waiting = (dec_req & ~dec_gnt) | (dec_pending & ~dec_valid).
  - It is low in the dec_valid cycle, so the decoder samples dec_data and advances that cycle.
  - waiting is 0 when dec_req=0 and nothing is pending.
- Ordering: iram accesses execute strictly in grant order.
  - A loader write granted after a decoder read to the same address does not affect that read's data.
  - A write granted before the read does.
- Requests whose inputs change while not granted are legal; only the values in the grant cycle matter.

Test Plan:
- Reset sequence: hold reset low 3 cycles with dec_req=1 → all outputs 0, no ram_en. Release → decoder reads adr 0x0010, dec_valid after 2 cycles (RD_LAT=1) with ram_rdata value 0xB6.
- Decoder only: dec_req held over 4 sequential addresses → grants on alternate cycles (one outstanding). waiting=1 except the dec_valid cycles; data matches the RAM model.
- Contention without lock: ld_req=1 and ld_we=1 writing 0x00..0x05, plus dec_req continuous → grants alternate dec/ld. No double grant. Loader write order is preserved in RAM.
- Lock burst: ld_lock=1 with 12 loader writes while dec_req=1, MAX_BURST=8 → 8 loader grants, 1 decoder grant, then the loader resumes. waiting stays high through the burst.
- Hazard: decoder read 0x20 granted, then loader write 0x20=0x99 next cycle → dec_data returns the old value. A subsequent decoder read returns 0x99.
- Reset mid-read: assert reset in the cycle after a loader read grant → no ld_valid pulse; after release, ld_rdata=0 until the next read.
